// File: rtl/uart_rx.sv
// 8N1 UART receiver: 3-flop synchronizer, mid-bit sampling, one-cycle done strobe.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx #(
  parameter int BAUD_CNT_MAX = 434,
  parameter int HALF_CNT     = BAUD_CNT_MAX / 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CW = $clog2(BAUD_CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  logic fall, tick, mid;

  assign fall = !rx_s2_q && rx_s3_q;
  assign tick = (cnt_q == CW'(BAUD_CNT_MAX));
  assign mid  = (cnt_q == CW'(HALF_CNT));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (mid)  state_d = rx_s2_q ? IDLE : DATA;
      DATA: begin
        if (tick && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    data_d = data_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d  = par_q;
    perr_d = 1'b0;
`endif
    if (state_q == IDLE || state_d != state_q) cnt_d = '0;
    if (state_q != DATA) bit_d = '0;
    if (tick) begin
      unique case (state_q)
        DATA: begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: par_d = rx_s2_q;
`endif
        STOP: begin
          // a low stop bit outranks any parity verdict
          if (!rx_s2_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != ^sh_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            done_d = 1'b1;
            data_d = sh_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the serial input path; sits directly upstream of the FIFO/summing datapath and the UART transmitter.
- Oversamples the asynchronous rx line with sys_clk, validates the start bit, samples 8 data bits LSB-first at mid-bit and checks the stop bit.
- Presents each received byte in parallel with a one-cycle done strobe. data_out/rx_done may drive the transmitter's data_in/tx_en directly for loopback.

Parameters:
- BAUD_CNT_MAX, 434, bit period minus one in sys_clk cycles (434 = 115200 baud at 50 MHz; 5207 = 9600 baud).
- HALF_CNT, BAUD_CNT_MAX/2 (217), mid-bit offset used for start-bit validation.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  asynchronous serial input; idle high.
- data_out  output  8  last correctly received byte.
- rx_done  output  1  one-cycle pulse: a new byte is valid on data_out.
- frame_err  output  1  one-cycle pulse: stop bit was sampled low; byte discarded.
- busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset values: data_out=8'h00, rx_done=0, frame_err=0, busy=0, state=IDLE, all counters 0, synchronizer flops=1.
- Reset mid-frame aborts the frame immediately. No pulse is produced for that frame.
- Input conditioning: a 3-flop chain rx_s1→rx_s2→rx_s3. Only rx_s2 and rx_s3 are used by the logic.
- Start detect: falling edge = rx_s2==0 && rx_s3==1. It is honoured only in IDLE.
- baud_cnt: 0..BAUD_CNT_MAX, wraps to 0, held at 0 in IDLE, cleared on every state change.
- bit_cnt: 0..7, counts data bits.
- IDLE: on a falling edge go to START with baud_cnt=0.
- START: at baud_cnt==HALF_CNT, sample rx_s2.
  - If 0, go to DATA, baud_cnt=0, bit_cnt=0.
  - If 1, treat as a glitch: return to IDLE with no pulse.
- DATA: at baud_cnt==BAUD_CNT_MAX (mid-bit), shift rx_s2 into shift_reg[7] (right shift, so LSB arrives first).
  - bit_cnt increments after each sample.
  - After the 8th sample (bit_cnt==7), go to STOP (or PARITY, see Optional Feature).
- STOP: at baud_cnt==BAUD_CNT_MAX, sample rx_s2.
  - If 1: data_out<=shift_reg and rx_done=1 for exactly one cycle.
  - If 0: frame_err=1 for one cycle and data_out is unchanged.
  - Either way, return to IDLE in the same cycle. Returning at mid-stop-bit gives half a bit of margin for back-to-back frames.
- Held-low line (break): no retrigger until rx has returned high and a new falling edge occurs.
- rx_done and frame_err are mutually exclusive and never assert in consecutive cycles for the same frame.
- Latency: rx_done rises 2 sync cycles + 9.5 bit periods after the start edge at the pin, i.e. 4133..4137 clocks at the default setting.
- No backpressure. The consumer must take data_out within one frame time; data_out holds until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. The parity bit is sampled at baud_cnt==BAUD_CNT_MAX and compared with even parity (^shift_reg).
  - A parity_err output (1 bit, reset 0) is added. On mismatch, parity_err pulses one cycle in the stop-sample cycle instead of rx_done, and data_out is unchanged.
  - Frame format becomes 8E1. frame_err takes priority over parity_err.
- Not defined: no PARITY state and no parity_err port; frame format is 8N1.

Test Plan:
- Reset, then drive byte 8'h55 8N1 at 435 clk/bit → busy rises about 3 clocks after the start edge. rx_done pulses once, 4133..4137 clocks after the edge, with data_out=8'h55.
- Two back-to-back frames 8'hA3, 8'h0F with no idle gap → two rx_done pulses 4350 clocks apart (±2), data_out=8'hA3 then 8'h0F.
- Start glitch: rx low for 100 clocks then high → busy pulses, no rx_done, no frame_err, state back in IDLE before clock 225.
- Frame 8'hFF with stop bit forced low → frame_err pulses one cycle, rx_done stays 0, data_out keeps the previous value. Line then held low 10 bit times → no further activity until rx goes high and a new start arrives.
- Assert rst during bit 4 of frame 8'h3C → outputs go to reset values immediately. The next clean frame 8'h3C gives rx_done with data_out=8'h3C.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 1 → rx_done, data_out=8'h07. Resend with parity bit 0 → parity_err pulse, no rx_done.
